// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    localparam logic PORT_PIPE     = 1'b0;
    localparam logic PORT_DBG      = 1'b1;
    localparam int   ACCESS_BYTES  = 8;
    localparam int   MEM_BYTES_DEF = 64;

endpackage

// File: rtl/dmem_rr_arb.sv
// Two-way grant logic: round-robin by default, fixed port-0 priority when
// DMEM_ARB_FIXED_PRIO_EN is defined.
module dmem_rr_arb
    import dmem_arb_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic grant0,
    output logic grant1,
    output logic grant_id
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
    logic unused_clk_rst;
    assign unused_clk_rst = clock ^ reset;

    assign grant0 = take & req0;
    assign grant1 = take & req1 & !req0;
`else
    logic rr_last;

    // rr_last remembers the most recent winner; the other port wins the next tie
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            rr_last <= PORT_DBG;
        else if (grant0 | grant1)
            rr_last <= grant1;
    end

    assign grant0 = take & req0 & (!req1 | (rr_last == PORT_DBG));
    assign grant1 = take & req1 & (!req0 | (rr_last == PORT_PIPE));
`endif

    assign grant_id = grant1 ? PORT_DBG : PORT_PIPE;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the 64-byte data memory: IDLE -> ACCESS -> RESPOND.
// Optional macro DMEM_ARB_FIXED_PRIO_EN selects fixed port-0 priority on ties.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_write,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    output logic              p0_rsp_valid,
    input  logic              p0_rsp_ready,
    output logic [DATA_W-1:0] p0_rsp_rdata,
    output logic              p0_rsp_err,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_write,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    output logic              p1_rsp_valid,
    input  logic              p1_rsp_ready,
    output logic [DATA_W-1:0] p1_rsp_rdata,
    output logic              p1_rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - ACCESS_BYTES);

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              write_q;
    logic              owner_q;
    logic              err_q;

    logic              take;
    logic              grant0, grant1, grant_id;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              win_write;

    assign take = (state == IDLE) && !reset;

    dmem_rr_arb u_arb (
        .clock    (clock),
        .reset    (reset),
        .req0     (p0_req_valid),
        .req1     (p1_req_valid),
        .take     (take),
        .grant0   (grant0),
        .grant1   (grant1),
        .grant_id (grant_id)
    );

    assign win_addr  = grant_id ? p1_req_addr  : p0_req_addr;
    assign win_wdata = grant_id ? p1_req_wdata : p0_req_wdata;
    assign win_write = grant_id ? p1_req_write : p0_req_write;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next   = state;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        p0_rsp_valid = 1'b0;
        p1_rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (grant0 | grant1)
                    state_next = ACCESS;
            end
            ACCESS: begin
                mem_write  = write_q & !err_q;
                mem_read   = !write_q & !err_q;
                state_next = RESPOND;
            end
            RESPOND: begin
                p0_rsp_valid = (owner_q == PORT_PIPE);
                p1_rsp_valid = (owner_q == PORT_DBG);
                if (owner_q == PORT_DBG ? p1_rsp_ready : p0_rsp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture at grant; read data captured at the end of the ACCESS cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            owner_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (grant0 | grant1) begin
                addr_q  <= win_addr;
                wdata_q <= win_wdata;
                write_q <= win_write;
                owner_q <= grant_id;
                err_q   <= (win_addr > LAST_ADDR);
            end
            if (state == ACCESS)
                rdata_q <= mem_read ? mem_rdata : '0;
        end
    end

    assign p0_req_ready = grant0;
    assign p1_req_ready = grant1;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign busy         = (state != IDLE);

    assign p0_rsp_rdata = (owner_q == PORT_PIPE) ? rdata_q : '0;
    assign p1_rsp_rdata = (owner_q == PORT_DBG)  ? rdata_q : '0;
    assign p0_rsp_err   = (owner_q == PORT_PIPE) & err_q;
    assign p1_rsp_err   = (owner_q == PORT_DBG)  & err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a 64-byte memory model.
module tb_dmem_arbiter;

    logic        clock;
    logic        reset;
    logic        p0_req_valid, p0_req_ready, p0_req_write;
    logic [63:0] p0_req_addr, p0_req_wdata;
    logic        p0_rsp_valid, p0_rsp_ready, p0_rsp_err;
    logic [63:0] p0_rsp_rdata;
    logic        p1_req_valid, p1_req_ready, p1_req_write;
    logic [63:0] p1_req_addr, p1_req_wdata;
    logic        p1_rsp_valid, p1_rsp_ready, p1_rsp_err;
    logic [63:0] p1_rsp_rdata;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, mem_read, busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:63];

    dmem_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .p0_req_valid (p0_req_valid),
        .p0_req_ready (p0_req_ready),
        .p0_req_write (p0_req_write),
        .p0_req_addr  (p0_req_addr),
        .p0_req_wdata (p0_req_wdata),
        .p0_rsp_valid (p0_rsp_valid),
        .p0_rsp_ready (p0_rsp_ready),
        .p0_rsp_rdata (p0_rsp_rdata),
        .p0_rsp_err   (p0_rsp_err),
        .p1_req_valid (p1_req_valid),
        .p1_req_ready (p1_req_ready),
        .p1_req_write (p1_req_write),
        .p1_req_addr  (p1_req_addr),
        .p1_req_wdata (p1_req_wdata),
        .p1_rsp_valid (p1_rsp_valid),
        .p1_rsp_ready (p1_rsp_ready),
        .p1_rsp_rdata (p1_rsp_rdata),
        .p1_rsp_err   (p1_rsp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .mem_rdata    (mem_rdata),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Byte-addressed little-endian memory, byte i = i at power-up
    initial for (int i = 0; i < 64; i++) mem[i] = 8'(i);

    always @(posedge clock) begin
        if (mem_write && mem_addr <= 64'd56)
            for (int i = 0; i < 8; i++) mem[int'(mem_addr) + i] <= mem_wdata[8*i +: 8];
    end

    always_comb begin
        mem_rdata = '0;
        if (mem_addr <= 64'd56)
            for (int i = 0; i < 8; i++) mem_rdata[8*i +: 8] = mem[int'(mem_addr) + i];
    end

    // Drives one request on a port and waits for its response; consumes the
    // response only when that port's rsp_ready is already high.
    task automatic issue(input int port, input logic wr, input logic [63:0] addr,
                         input logic [63:0] wdata, output logic [63:0] rdata,
                         output logic err, output int lat, output logic rd_seen,
                         output logic wr_seen, output logic ok);
        int n;
        logic vld;
        ok = 1'b0; rdata = '0; err = 1'b0; lat = 0; rd_seen = 1'b0; wr_seen = 1'b0;
        @(negedge clock);
        if (port == 0) begin
            p0_req_valid = 1'b1; p0_req_write = wr; p0_req_addr = addr; p0_req_wdata = wdata;
        end else begin
            p1_req_valid = 1'b1; p1_req_write = wr; p1_req_addr = addr; p1_req_wdata = wdata;
        end
        n = 0;
        #1;
        while (n < 20 && !((port == 0) ? p0_req_ready : p1_req_ready)) begin
            @(negedge clock); #1; n++;
        end
        if (n < 20) begin
            @(posedge clock); #1;
            p0_req_valid = 1'b0; p1_req_valid = 1'b0;
            lat = 1;
            vld = (port == 0) ? p0_rsp_valid : p1_rsp_valid;
            while (lat < 20 && !vld) begin
                rd_seen = rd_seen | mem_read;
                wr_seen = wr_seen | mem_write;
                @(posedge clock); #1; lat++;
                vld = (port == 0) ? p0_rsp_valid : p1_rsp_valid;
            end
            if (vld) begin
                ok    = 1'b1;
                rdata = (port == 0) ? p0_rsp_rdata : p1_rsp_rdata;
                err   = (port == 0) ? p0_rsp_err : p1_rsp_err;
                if ((port == 0) ? p0_rsp_ready : p1_rsp_ready) begin
                    @(posedge clock); #1;
                end
            end
        end else begin
            p0_req_valid = 1'b0; p1_req_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (busy !== 1'b0 || mem_write !== 1'b0 || mem_read !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: busy/wr/rd %b%b%b, want 000", busy, mem_write, mem_read);
        end
        checks++;
        if (mem_addr !== 64'h0 || mem_wdata !== 64'h0) begin
            errors++; $display("FAIL reset_mem_bus: addr %h wdata %h, want 0", mem_addr, mem_wdata);
        end
        checks++;
        if ({p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err, p0_req_ready, p1_req_ready} !== 6'b0) begin
            errors++; $display("FAIL reset_ports: got %b, want 000000",
                {p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err, p0_req_ready, p1_req_ready});
        end
        checks++;
        if (p0_rsp_rdata !== 64'h0 || p1_rsp_rdata !== 64'h0) begin
            errors++; $display("FAIL reset_rdata: %h %h, want 0", p0_rsp_rdata, p1_rsp_rdata);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_load();
        logic [63:0] rd; logic er, rs, ws, ok; int lat;
        issue(0, 1'b0, 64'd0, 64'd0, rd, er, lat, rs, ws, ok);
        checks++;
        if (!ok || lat !== 2) begin
            errors++; $display("FAIL load0_latency: ok %b lat %0d, want ok 1 lat 2", ok, lat);
        end
        checks++;
        if (rd !== 64'h0706050403020100 || er !== 1'b0) begin
            errors++; $display("FAIL load0_data: rdata %h err %b, want 0706050403020100 0", rd, er);
        end
        checks++;
        if (rs !== 1'b1 || ws !== 1'b0) begin
            errors++; $display("FAIL load0_strobe: rd %b wr %b, want 1 0", rs, ws);
        end
        issue(0, 1'b0, 64'd3, 64'd0, rd, er, lat, rs, ws, ok);
        checks++;
        if (!ok || rd !== 64'h0A09080706050403 || er !== 1'b0) begin
            errors++; $display("FAIL load_unaligned: ok %b rdata %h err %b, want 0A09080706050403 0", ok, rd, er);
        end
        issue(0, 1'b0, 64'd56, 64'd0, rd, er, lat, rs, ws, ok);
        checks++;
        if (!ok || rd !== 64'h3F3E3D3C3B3A3938 || er !== 1'b0) begin
            errors++; $display("FAIL load_last: ok %b rdata %h err %b, want 3F3E3D3C3B3A3938 0", ok, rd, er);
        end
    endtask

    task automatic test_store();
        logic [63:0] rd; logic er, rs, ws, ok; int lat;
        issue(1, 1'b1, 64'd16, 64'hDEADBEEFCAFEF00D, rd, er, lat, rs, ws, ok);
        checks++;
        if (!ok || rd !== 64'h0 || er !== 1'b0) begin
            errors++; $display("FAIL store_rsp: ok %b rdata %h err %b, want 0 0", ok, rd, er);
        end
        checks++;
        if (ws !== 1'b1 || rs !== 1'b0) begin
            errors++; $display("FAIL store_strobe: wr %b rd %b, want 1 0", ws, rs);
        end
        issue(1, 1'b0, 64'd16, 64'd0, rd, er, lat, rs, ws, ok);
        checks++;
        if (!ok || rd !== 64'hDEADBEEFCAFEF00D || er !== 1'b0) begin
            errors++; $display("FAIL store_readback: rdata %h err %b, want DEADBEEFCAFEF00D 0", rd, er);
        end
    endtask

    task automatic test_error();
        logic [63:0] rd; logic er, rs, ws, ok; int lat;
        issue(0, 1'b0, 64'd57, 64'd0, rd, er, lat, rs, ws, ok);
        checks++;
        if (!ok || er !== 1'b1 || rd !== 64'h0 || rs !== 1'b0 || ws !== 1'b0) begin
            errors++; $display("FAIL err_57: err %b rdata %h rd %b wr %b, want 1 0 0 0", er, rd, rs, ws);
        end
        issue(0, 1'b0, 64'h1_0000_0000, 64'd0, rd, er, lat, rs, ws, ok);
        checks++;
        if (!ok || er !== 1'b1 || rd !== 64'h0 || rs !== 1'b0 || ws !== 1'b0) begin
            errors++; $display("FAIL err_high: err %b rdata %h rd %b wr %b, want 1 0 0 0", er, rd, rs, ws);
        end
        issue(0, 1'b1, 64'd60, 64'hFFFF_FFFF_FFFF_FFFF, rd, er, lat, rs, ws, ok);
        checks++;
        if (!ok || er !== 1'b1 || ws !== 1'b0 || {mem[63], mem[62], mem[61], mem[60]} !== 32'h3F3E3D3C) begin
            errors++; $display("FAIL err_store: err %b wr %b bytes %h, want 1 0 3F3E3D3C",
                er, ws, {mem[63], mem[62], mem[61], mem[60]});
        end
        issue(0, 1'b0, 64'd8, 64'd0, rd, er, lat, rs, ws, ok);
        checks++;
        if (!ok || rd !== 64'h0F0E0D0C0B0A0908 || er !== 1'b0) begin
            errors++; $display("FAIL err_recover: rdata %h err %b, want 0F0E0D0C0B0A0908 0", rd, er);
        end
    endtask

    task automatic test_arbitration();
        int grants[4];
        int ng;
        int cyc;
        int exp_g[4];
`ifdef DMEM_ARB_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0};
`else
        exp_g = '{0, 1, 0, 1};
`endif
        @(negedge clock);
        reset = 1'b1;
        #1;
        @(negedge clock);
        reset = 1'b0;
        p0_req_valid = 1'b1; p0_req_write = 1'b0; p0_req_addr = 64'd0;
        p1_req_valid = 1'b1; p1_req_write = 1'b0; p1_req_addr = 64'd8;
        ng = 0; cyc = 0;
        while (ng < 4 && cyc < 20) begin
            #1;
            if (p0_req_ready && p1_req_ready) begin
                checks++; errors++; $display("FAIL arb_double_grant: both ready at cycle %0d, want one", cyc);
            end else if (p0_req_ready) begin
                grants[ng] = 0; ng++;
            end else if (p1_req_ready) begin
                grants[ng] = 1; ng++;
            end
            if (ng < 4) begin
                @(negedge clock); cyc++;
            end
        end
        checks++;
        if (ng !== 4) begin
            errors++; $display("FAIL arb_grant_count: got %0d grants, want 4", ng);
        end
        for (int i = 0; i < ng; i++) begin
            checks++;
            if (grants[i] !== exp_g[i]) begin
                errors++; $display("FAIL arb_order[%0d]: got port %0d, want port %0d", i, grants[i], exp_g[i]);
            end
        end
        @(posedge clock); #1;
        p0_req_valid = 1'b0; p1_req_valid = 1'b0;
        cyc = 0;
        while (busy && cyc < 20) begin
            @(posedge clock); #1; cyc++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL arb_drain: busy %b, want 0", busy);
        end
    endtask

    task automatic test_stall();
        logic [63:0] rd; logic er, rs, ws, ok; int lat;
        p0_rsp_ready = 1'b0;
        issue(0, 1'b0, 64'd8, 64'd0, rd, er, lat, rs, ws, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL stall_rsp: no response, want p0_rsp_valid");
        end
        p1_req_valid = 1'b1; p1_req_write = 1'b0; p1_req_addr = 64'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            checks++;
            if (p0_rsp_valid !== 1'b1 || p0_rsp_rdata !== 64'h0F0E0D0C0B0A0908 || busy !== 1'b1) begin
                errors++; $display("FAIL stall_hold[%0d]: valid %b rdata %h busy %b, want 1 0F0E0D0C0B0A0908 1",
                    i, p0_rsp_valid, p0_rsp_rdata, busy);
            end
            checks++;
            if (p1_req_ready !== 1'b0 || p1_rsp_valid !== 1'b0) begin
                errors++; $display("FAIL stall_p1[%0d]: ready %b rsp_valid %b, want 0 0", i, p1_req_ready, p1_rsp_valid);
            end
        end
        @(negedge clock);
        p1_req_valid = 1'b0;
        p0_rsp_ready = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (busy !== 1'b0 || p0_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL stall_release: busy %b valid %b, want 0 0", busy, p0_rsp_valid);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [63:0] rd; logic er, rs, ws, ok; int lat; int n;
        @(negedge clock);
        p0_req_valid = 1'b1; p0_req_write = 1'b1; p0_req_addr = 64'd24; p0_req_wdata = 64'h1122334455667788;
        n = 0;
        #1;
        while (n < 20 && !p0_req_ready) begin
            @(negedge clock); #1; n++;
        end
        @(posedge clock); #1;
        p0_req_valid = 1'b0;
        checks++;
        if (mem_write !== 1'b1) begin
            errors++; $display("FAIL rst_access_wr: mem_write %b, want 1", mem_write);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (mem_write !== 1'b0 || busy !== 1'b0 || mem_addr !== 64'h0 || mem_wdata !== 64'h0 || p0_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rst_async: wr %b busy %b addr %h wdata %h valid %b, want all 0",
                mem_write, busy, mem_addr, mem_wdata, p0_rsp_valid);
        end
        @(posedge clock); #1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if ({mem[31], mem[30], mem[29], mem[28], mem[27], mem[26], mem[25], mem[24]} !== 64'h1F1E1D1C1B1A1918) begin
            errors++; $display("FAIL rst_mem_intact: got %h, want 1F1E1D1C1B1A1918",
                {mem[31], mem[30], mem[29], mem[28], mem[27], mem[26], mem[25], mem[24]});
        end
        checks++;
        if (p0_rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_dropped: valid %b busy %b, want 0 0", p0_rsp_valid, busy);
        end
        issue(0, 1'b0, 64'd24, 64'd0, rd, er, lat, rs, ws, ok);
        checks++;
        if (!ok || rd !== 64'h1F1E1D1C1B1A1918 || er !== 1'b0) begin
            errors++; $display("FAIL rst_readback: rdata %h err %b, want 1F1E1D1C1B1A1918 0", rd, er);
        end
    endtask

    initial begin
        reset = 1'b1;
        p0_req_valid = 1'b0; p0_req_write = 1'b0; p0_req_addr = '0; p0_req_wdata = '0; p0_rsp_ready = 1'b1;
        p1_req_valid = 1'b0; p1_req_write = 1'b0; p1_req_addr = '0; p1_req_wdata = '0; p1_rsp_ready = 1'b1;
        test_reset();
        test_load();
        test_store();
        test_error();
        test_arbitration();
        test_stall();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
